// File: rtl/axi_lite_rr_hub_if.sv
// AXI-lite channel bundle for the round-robin hub.
// The Master modport drives requests; the Slave modport drives responses.
interface AXI_ift #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64
);
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic                        awvalid, awready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid, wready;
    logic [1:0]                  bresp;
    logic                        bvalid, bready;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic                        arvalid, arready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid, rready;

    modport Master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport Slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_rr_hub.sv
// Single-transaction AXI-lite hub: round-robin over masters, address decode to slaves.
// Define RR_HUB_TIMEOUT_EN to add a slave-handshake watchdog that answers SLVERR.
module axi_lite_rr_hub #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int NUM_MASTERS    = 4,
    parameter int NUM_SLAVES     = 3,
    parameter logic [NUM_SLAVES-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_LEN  = '0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic   clk,
    input  logic   rstn,
    AXI_ift.Slave  master [NUM_MASTERS],
    AXI_ift.Master slave  [NUM_SLAVES],
    output logic [2:0] grant_id
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, ERR_RESP} state_t;

    logic [NUM_MASTERS-1:0][AW-1:0]   m_awaddr, m_araddr;
    logic [NUM_MASTERS-1:0][DW-1:0]   m_wdata, m_rdata;
    logic [NUM_MASTERS-1:0][DW/8-1:0] m_wstrb;
    logic [NUM_MASTERS-1:0][1:0]      m_bresp, m_rresp;
    logic [NUM_MASTERS-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [NUM_MASTERS-1:0] m_arvalid, m_arready, m_rvalid, m_rready;

    logic [NUM_SLAVES-1:0][AW-1:0]   s_awaddr, s_araddr;
    logic [NUM_SLAVES-1:0][DW-1:0]   s_wdata, s_rdata;
    logic [NUM_SLAVES-1:0][DW/8-1:0] s_wstrb;
    logic [NUM_SLAVES-1:0][1:0]      s_bresp, s_rresp;
    logic [NUM_SLAVES-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [NUM_SLAVES-1:0] s_arvalid, s_arready, s_rvalid, s_rready;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_mst
        assign m_awaddr[i]  = master[i].awaddr;
        assign m_awvalid[i] = master[i].awvalid;
        assign m_wdata[i]   = master[i].wdata;
        assign m_wstrb[i]   = master[i].wstrb;
        assign m_wvalid[i]  = master[i].wvalid;
        assign m_bready[i]  = master[i].bready;
        assign m_araddr[i]  = master[i].araddr;
        assign m_arvalid[i] = master[i].arvalid;
        assign m_rready[i]  = master[i].rready;
        assign master[i].awready = m_awready[i];
        assign master[i].wready  = m_wready[i];
        assign master[i].bresp   = m_bresp[i];
        assign master[i].bvalid  = m_bvalid[i];
        assign master[i].arready = m_arready[i];
        assign master[i].rdata   = m_rdata[i];
        assign master[i].rresp   = m_rresp[i];
        assign master[i].rvalid  = m_rvalid[i];
    end

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slv
        assign slave[i].awaddr  = s_awaddr[i];
        assign slave[i].awvalid = s_awvalid[i];
        assign slave[i].wdata   = s_wdata[i];
        assign slave[i].wstrb   = s_wstrb[i];
        assign slave[i].wvalid  = s_wvalid[i];
        assign slave[i].bready  = s_bready[i];
        assign slave[i].araddr  = s_araddr[i];
        assign slave[i].arvalid = s_arvalid[i];
        assign slave[i].rready  = s_rready[i];
        assign s_awready[i] = slave[i].awready;
        assign s_wready[i]  = slave[i].wready;
        assign s_bresp[i]   = slave[i].bresp;
        assign s_bvalid[i]  = slave[i].bvalid;
        assign s_arready[i] = slave[i].arready;
        assign s_rdata[i]   = slave[i].rdata;
        assign s_rresp[i]   = slave[i].rresp;
        assign s_rvalid[i]  = slave[i].rvalid;
    end

    state_t          state_q, state_d;
    logic [MW-1:0]   gnt_q, gnt_d, rr_q, rr_d, pick, nxt_ptr;
    logic [SW-1:0]   sel_q, sel_d, dec_sel;
    logic            miss_q, miss_d, wr_q, wr_d, awd_q, awd_d, wd_q, wd_d;
    logic [1:0]      err_q, err_d;
    logic            found, dec_miss, aw_now, w_now, to_hit;
    logic [AW-1:0]   dec_addr;
    logic [NUM_MASTERS-1:0] req;

`ifdef RR_HUB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) cnt_d = '0;
        else if (state_q == RD_ADDR || state_q == WR_ADDR) cnt_d = cnt_q + 1'b1;
    end

    assign to_hit = !miss_q && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    assign req      = m_arvalid | m_awvalid;
    assign nxt_ptr  = (gnt_q == MW'(NUM_MASTERS - 1)) ? '0 : gnt_q + 1'b1;
    assign grant_id = (state_q == IDLE) ? 3'd0 : 3'(gnt_q);

    // First requester at or after rr_q, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && req[MW'(idx)]) begin
                found = 1'b1;
                pick  = MW'(idx);
            end
        end
    end

    // Compare one bit wider so base+len at the top of the map does not wrap; lowest index wins.
    always_comb begin
        dec_addr = m_awvalid[pick] ? m_awaddr[pick] : m_araddr[pick];
        dec_miss = 1'b1;
        dec_sel  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ({1'b0, dec_addr} >= {1'b0, SLAVE_BASE[i]} &&
                {1'b0, dec_addr} <  ({1'b0, SLAVE_BASE[i]} + {1'b0, SLAVE_LEN[i]})) begin
                dec_miss = 1'b0;
                dec_sel  = SW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            sel_q   <= '0;
            miss_q  <= 1'b0;
            wr_q    <= 1'b0;
            awd_q   <= 1'b0;
            wd_q    <= 1'b0;
            err_q   <= 2'b11;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            miss_q  <= miss_d;
            wr_q    <= wr_d;
            awd_q   <= awd_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        m_awready = '0; m_wready = '0; m_bvalid = '0; m_bresp = '0;
        m_arready = '0; m_rvalid = '0; m_rresp = '0; m_rdata = '0;
        s_awvalid = '0; s_awaddr = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_bready = '0;
        s_arvalid = '0; s_araddr = '0; s_rready = '0;
        state_d = state_q; gnt_d = gnt_q; rr_d = rr_q; sel_d = sel_q; miss_d = miss_q;
        wr_d = wr_q; awd_d = awd_q; wd_d = wd_q; err_d = err_q;
        aw_now = 1'b0; w_now = 1'b0;

        case (state_q)
            IDLE: if (found) begin
                gnt_d   = pick;
                sel_d   = dec_sel;
                miss_d  = dec_miss;
                wr_d    = m_awvalid[pick];
                awd_d   = 1'b0;
                wd_d    = 1'b0;
                err_d   = 2'b11;
                state_d = m_awvalid[pick] ? WR_ADDR : RD_ADDR;
            end
            RD_ADDR: begin
                if (miss_q) m_arready[gnt_q] = 1'b1;
                else begin
                    s_arvalid[sel_q] = m_arvalid[gnt_q];
                    s_araddr[sel_q]  = m_araddr[gnt_q];
                    m_arready[gnt_q] = s_arready[sel_q];
                end
                if (m_arvalid[gnt_q] && m_arready[gnt_q]) state_d = miss_q ? ERR_RESP : RD_DATA;
                else if (to_hit) begin
                    state_d = ERR_RESP;
                    err_d   = 2'b10;
                end
            end
            RD_DATA: begin
                m_rvalid[gnt_q] = s_rvalid[sel_q];
                m_rdata[gnt_q]  = s_rdata[sel_q];
                m_rresp[gnt_q]  = s_rresp[sel_q];
                s_rready[sel_q] = m_rready[gnt_q];
                if (s_rvalid[sel_q] && m_rready[gnt_q]) begin
                    state_d = IDLE;
                    rr_d    = nxt_ptr;
                end
            end
            WR_ADDR: begin
                if (miss_q) begin
                    m_awready[gnt_q] = !awd_q;
                    m_wready[gnt_q]  = !wd_q;
                end else begin
                    s_awvalid[sel_q] = m_awvalid[gnt_q] && !awd_q;
                    s_awaddr[sel_q]  = m_awaddr[gnt_q];
                    m_awready[gnt_q] = s_awready[sel_q] && !awd_q;
                    s_wvalid[sel_q]  = m_wvalid[gnt_q] && !wd_q;
                    s_wdata[sel_q]   = m_wdata[gnt_q];
                    s_wstrb[sel_q]   = m_wstrb[gnt_q];
                    m_wready[gnt_q]  = s_wready[sel_q] && !wd_q;
                end
                aw_now = awd_q || (m_awvalid[gnt_q] && m_awready[gnt_q]);
                w_now  = wd_q  || (m_wvalid[gnt_q]  && m_wready[gnt_q]);
                awd_d  = aw_now;
                wd_d   = w_now;
                if (aw_now && w_now) state_d = miss_q ? ERR_RESP : WR_RESP;
                else if (to_hit) begin
                    state_d = ERR_RESP;
                    err_d   = 2'b10;
                end
            end
            WR_RESP: begin
                m_bvalid[gnt_q] = s_bvalid[sel_q];
                m_bresp[gnt_q]  = s_bresp[sel_q];
                s_bready[sel_q] = m_bready[gnt_q];
                if (s_bvalid[sel_q] && m_bready[gnt_q]) begin
                    state_d = IDLE;
                    rr_d    = nxt_ptr;
                end
            end
            ERR_RESP: begin
                if (wr_q) begin
                    m_bvalid[gnt_q] = 1'b1;
                    m_bresp[gnt_q]  = err_q;
                end else begin
                    m_rvalid[gnt_q] = 1'b1;
                    m_rresp[gnt_q]  = err_q;
                end
                if (wr_q ? m_bready[gnt_q] : m_rready[gnt_q]) begin
                    state_d = IDLE;
                    rr_d    = nxt_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/axi_lite_rr_hub.md
AXI_LITE_RR_HUB -- requirements
Module: axi_lite_rr_hub

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, data width.
REQ-003 SHALL have parameter NUM_MASTERS, default 4, range 1..8, number of upstream ports.
REQ-004 SHALL have parameter NUM_SLAVES, default 3, range 1..8, number of downstream regions.
REQ-005 SHALL have parameter SLAVE_BASE, default all-zero, array [NUM_SLAVES] of AXI_ADDR_WIDTH region base addresses.
REQ-006 SHALL have parameter SLAVE_LEN, default all-zero, array [NUM_SLAVES] of region lengths in bytes.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit; used only under the Configuration macro.
REQ-008 clk  input  1  single clock; all logic on rising edge.
REQ-009 rstn  input  1  reset; asynchronous, active-low.
REQ-010 master  AXI_ift.Slave  array [NUM_MASTERS]  upstream AXI-lite ports; index 0 is the fetch port.
REQ-011 slave  AXI_ift.Master  array [NUM_SLAVES]  downstream AXI-lite ports.
REQ-012 grant_id  output  3  index of the currently granted master; 0 when IDLE.

Function
REQ-013 SHALL carry exactly one transaction at a time, with no outstanding overlap.
REQ-014 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP and ERR_RESP.
REQ-015 In IDLE, a master SHALL request when its arvalid or awvalid is high; round-robin SHALL pick the first requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
REQ-016 When the granted master has both awvalid and arvalid high, the write SHALL be served first.
REQ-017 Decode SHALL mark region i as hit when SLAVE_BASE[i] <= addr < SLAVE_BASE[i]+SLAVE_LEN[i], compared at AXI_ADDR_WIDTH+1 bits so the end does not wrap; on overlap the lowest index SHALL win.
REQ-018 Grant latency: IDLE->RD_ADDR/WR_ADDR SHALL occur one cycle after a request is seen; the address and data phases SHALL then pass combinationally between the granted master and the selected slave.
REQ-019 WR_ADDR SHALL forward aw and w together, leave only after both handshakes complete (in either order), then go to WR_RESP.
REQ-020 RD_DATA and WR_RESP SHALL forward rresp/bresp unchanged and return to IDLE on the master's r or b handshake.
REQ-021 A decode miss SHALL accept the address (and the W beat for writes) without touching any slave, go to ERR_RESP, and return resp=2'b11 (DECERR) with rdata=0.
REQ-022 rr_ptr SHALL become (grant_id+1) mod NUM_MASTERS on transaction completion only.
REQ-023 Ungranted masters SHALL see arready, awready, wready, rvalid and bvalid held at 0.
REQ-024 Unselected slaves SHALL see all valid and ready signals held at 0.

Reset
REQ-025 rstn low SHALL immediately force IDLE, rr_ptr=0, grant_id=0, and all valid/ready outputs to 0, including mid-transaction.
REQ-026 After reset a dropped transaction SHALL NOT be replayed; the first request SHALL be arbitrated starting at master 0.

Configuration
REQ-027 Macro RR_HUB_TIMEOUT_EN defined: a counter SHALL clear on entering RD_ADDR/WR_ADDR and count while awaiting a slave handshake; on reaching TIMEOUT_CYCLES the hub SHALL drop slave valids, go to ERR_RESP and return resp=2'b10 (SLVERR).
REQ-028 Macro RR_HUB_TIMEOUT_EN undefined: no counter SHALL exist and the hub SHALL wait indefinitely.

Verification
REQ-029 Masters 0,1,3 assert arvalid in the same cycle, each to a valid region -> served in order 0,1,3, and rr_ptr reads 0 after the third completes.
REQ-030 Master 2 asserts both awvalid and arvalid to 0x8000_0000 (region 2) -> write completes with bresp=0 before the read is granted.
REQ-031 Read to an address outside every region, e.g. 0xDEAD_0000 -> no slave valid asserted; rresp=2'b11, rdata=0.
REQ-032 Region 0 at base 0x0, len 0x1000; access at 0xFFF hits slave 0 and access at 0x1000 decodes to slave 1 or DECERR.
REQ-033 rstn pulsed low during RD_DATA -> all outputs 0 within the same cycle; the next request from master 3 is granted, with grant_id=3.
REQ-034 RR_HUB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, slave never asserts arready -> rresp=2'b10 at cycle 17 after grant; the FSM returns to IDLE.
